// File: rtl/irq_priority_controller.sv
// 8259-style interrupt priority engine: IRR/ISR registers, rotating priority ring,
// two-pulse INTA acknowledge, EOI/AEOI and set-priority commands.
module irq_priority_controller #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic               level_mode_i,
   input  logic [NUM_IRQ-1:0] imr_i,
   input  logic               rotate_on_eoi_i,
   input  logic               aeoi_i,
   input  logic               inta_i,
   input  logic               eoi_valid_i,
   input  logic               eoi_specific_i,
   input  logic [ID_W-1:0]    eoi_level_i,
   input  logic               prio_set_valid_i,
   input  logic [ID_W-1:0]    prio_level_i,
   output logic               int_o,
   output logic               vector_valid_o,
   output logic [ID_W-1:0]    vector_id_o,
   output logic               spurious_o,
   output logic [NUM_IRQ-1:0] isr_o,
   output logic [NUM_IRQ-1:0] irr_o,
   output logic               dbg_state_o
);

   // Handshake: inta_i is a one-cycle pulse per bus cycle; the first pulse latches
   // the winner, the second produces a one-cycle vector_valid_o strobe.
   typedef enum logic {ST_IDLE = 1'b0, ST_ACK1 = 1'b1} state_t;

   state_t               state, state_n;
   logic [NUM_IRQ-1:0]   irr, irr_n, isr, isr_n, irq_prev;
   logic [ID_W-1:0]      lowest_prio, lowest_prio_n;
   logic [ID_W-1:0]      ack_id, ack_id_n;
   logic                 spur_flag, spur_flag_n;
   logic                 int_n, vv_n, sp_n;
   logic [ID_W-1:0]      vid_n;

   logic [NUM_IRQ-1:0]   pending;
   logic                 win_found, top_found, winner_ok;
   logic [ID_W-1:0]      win_id, top_id;
   logic [ID_W:0]        win_rank, top_rank;
   logic [NUM_IRQ-1:0]   ack_set, ack_clr, aeoi_clr, eoi_clr;

   // Channel at ring position k (k = 0 is highest priority).
   function automatic logic [ID_W-1:0] ring_idx(input logic [ID_W-1:0] lp, input int k);
      int s;
      s = int'(lp) + 1 + k;
      if (s >= NUM_IRQ) s = s - NUM_IRQ;
      return ID_W'(s);
   endfunction

   assign pending     = irr & ~imr_i;
   assign irr_o       = irr;
   assign isr_o       = isr;
   assign dbg_state_o = (state == ST_ACK1);

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_rank  = '0;
      top_found = 1'b0;
      top_id    = '0;
      top_rank  = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         if (!win_found && pending[ring_idx(lowest_prio, k)]) begin
            win_found = 1'b1;
            win_id    = ring_idx(lowest_prio, k);
            win_rank  = (ID_W+1)'(k);
         end
         if (!top_found && isr[ring_idx(lowest_prio, k)]) begin
            top_found = 1'b1;
            top_id    = ring_idx(lowest_prio, k);
            top_rank  = (ID_W+1)'(k);
         end
      end
      winner_ok = win_found && (!top_found || (win_rank < top_rank));
   end

   always_comb begin
      state_n       = state;
      ack_id_n      = ack_id;
      spur_flag_n   = spur_flag;
      int_n         = int_o;
      vv_n          = 1'b0;
      vid_n         = vector_id_o;
      sp_n          = 1'b0;
      lowest_prio_n = lowest_prio;
      ack_set       = '0;
      ack_clr       = '0;
      aeoi_clr      = '0;
      eoi_clr       = '0;

      case (state)
         ST_IDLE: begin
            int_n = winner_ok;
            if (inta_i) begin
               state_n = ST_ACK1;
               int_n   = 1'b0;
               if (winner_ok) begin
                  ack_id_n        = win_id;
                  spur_flag_n     = 1'b0;
                  ack_set[win_id] = 1'b1;
                  if (!level_mode_i) ack_clr[win_id] = 1'b1;
               end else begin
                  ack_id_n    = ID_W'(NUM_IRQ - 1);
                  spur_flag_n = 1'b1;
               end
            end
         end
         ST_ACK1: begin
            int_n = 1'b0;
            if (inta_i) begin
               state_n = ST_IDLE;
               vv_n    = 1'b1;
               vid_n   = ack_id;
               sp_n    = spur_flag;
               if (aeoi_i && !spur_flag) begin
                  aeoi_clr[ack_id] = 1'b1;
                  if (rotate_on_eoi_i) lowest_prio_n = ack_id;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // An explicit EOI rotation takes precedence over AEOI; set-priority beats both.
      if (eoi_valid_i) begin
         if (eoi_specific_i) begin
            if (int'(eoi_level_i) < NUM_IRQ) begin
               eoi_clr[eoi_level_i] = 1'b1;
               if (rotate_on_eoi_i) lowest_prio_n = eoi_level_i;
            end
         end else if (top_found) begin
            eoi_clr[top_id] = 1'b1;
            if (rotate_on_eoi_i) lowest_prio_n = top_id;
         end
      end
      if (prio_set_valid_i && (int'(prio_level_i) < NUM_IRQ))
         lowest_prio_n = prio_level_i;

      irr_n = level_mode_i ? irq_i : ((irr & ~ack_clr) | (irq_i & ~irq_prev));
      isr_n = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         irr            <= '0;
         isr            <= '0;
         irq_prev       <= '0;
         lowest_prio    <= ID_W'(NUM_IRQ - 1);
         ack_id         <= '0;
         spur_flag      <= 1'b0;
         int_o          <= 1'b0;
         vector_valid_o <= 1'b0;
         vector_id_o    <= '0;
         spurious_o     <= 1'b0;
      end else begin
         state          <= state_n;
         irr            <= irr_n;
         isr            <= isr_n;
         irq_prev       <= irq_i;
         lowest_prio    <= lowest_prio_n;
         ack_id         <= ack_id_n;
         spur_flag      <= spur_flag_n;
         int_o          <= int_n;
         vector_valid_o <= vv_n;
         vector_id_o    <= vid_n;
         spurious_o     <= sp_n;
      end
   end

endmodule

// File: tb/tb_irq_priority_controller.sv
// Bench for irq_priority_controller: ring-priority reference model, vector
// scoreboard queue with a decoupled monitor, directed scenarios then random traffic.
module tb_irq_priority_controller;
   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk, rst_n;
   logic [N-1:0]  irq_i, imr_i;
   logic          level_mode_i, rotate_on_eoi_i, aeoi_i, inta_i;
   logic          eoi_valid_i, eoi_specific_i, prio_set_valid_i;
   logic [IW-1:0] eoi_level_i, prio_level_i;
   logic          int_o, vector_valid_o, spurious_o, dbg_state_o;
   logic [IW-1:0] vector_id_o;
   logic [N-1:0]  isr_o, irr_o;

   irq_priority_controller #(.NUM_IRQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .level_mode_i(level_mode_i),
      .imr_i(imr_i), .rotate_on_eoi_i(rotate_on_eoi_i), .aeoi_i(aeoi_i),
      .inta_i(inta_i), .eoi_valid_i(eoi_valid_i), .eoi_specific_i(eoi_specific_i),
      .eoi_level_i(eoi_level_i), .prio_set_valid_i(prio_set_valid_i),
      .prio_level_i(prio_level_i), .int_o(int_o), .vector_valid_o(vector_valid_o),
      .vector_id_o(vector_id_o), .spurious_o(spurious_o), .isr_o(isr_o),
      .irr_o(irr_o), .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [IW:0] exp_q[$];
   int last_vec = -1;
   int last_spur = -1;

   // reference model state
   logic [N-1:0] m_irr, m_isr, m_prev;
   int m_lp, m_ack_id;
   bit m_in_ack, m_spur, m_int;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // distance below the top of the ring: 0 = highest priority
   function automatic int rank(input int ch);
      return (ch - m_lp - 1 + 2 * N) % N;
   endfunction

   function automatic int best(input logic [N-1:0] v);
      int b = -1;
      for (int i = 0; i < N; i++)
         if (v[i] && (b < 0 || rank(i) < rank(b))) b = i;
      return b;
   endfunction

   task automatic model_reset();
      m_irr = '0; m_isr = '0; m_prev = '0; m_lp = N - 1;
      m_ack_id = 0; m_in_ack = 0; m_spur = 0; m_int = 0;
   endtask

   // one clock: predict from rules, let the DUT clock, then compare registers
   task automatic tick();
      logic [N-1:0] n_irr, ack_set, ack_clr, aeoi_clr, eoi_clr;
      int n_lp, n_ack_id, win, top;
      bit n_in_ack, n_spur, n_int, ok;
      win = best(m_irr & ~imr_i);
      top = best(m_isr);
      ok = (win >= 0) && (top < 0 || rank(win) < rank(top));
      ack_set = '0; ack_clr = '0; aeoi_clr = '0; eoi_clr = '0;
      n_lp = m_lp; n_ack_id = m_ack_id; n_in_ack = m_in_ack; n_spur = m_spur;
      n_int = 0;
      if (!m_in_ack) begin
         n_int = ok;
         if (inta_i) begin
            n_in_ack = 1; n_int = 0;
            if (ok) begin
               n_ack_id = win; n_spur = 0; ack_set[win] = 1'b1;
               if (!level_mode_i) ack_clr[win] = 1'b1;
            end else begin
               n_ack_id = N - 1; n_spur = 1;
            end
         end
      end else if (inta_i) begin
         exp_q.push_back({m_spur, IW'(m_ack_id)});
         n_in_ack = 0;
         if (aeoi_i && !m_spur) begin
            aeoi_clr[m_ack_id] = 1'b1;
            if (rotate_on_eoi_i) n_lp = m_ack_id;
         end
      end
      if (eoi_valid_i) begin
         if (eoi_specific_i) begin
            eoi_clr[eoi_level_i] = 1'b1;
            if (rotate_on_eoi_i) n_lp = eoi_level_i;
         end else if (top >= 0) begin
            eoi_clr[top] = 1'b1;
            if (rotate_on_eoi_i) n_lp = top;
         end
      end
      if (prio_set_valid_i) n_lp = prio_level_i;
      n_irr = level_mode_i ? irq_i : ((m_irr & ~ack_clr) | (irq_i & ~m_prev));

      @(posedge clk); #1;
      m_isr = (m_isr & ~eoi_clr & ~aeoi_clr) | ack_set;
      m_irr = n_irr; m_prev = irq_i; m_lp = n_lp; m_ack_id = n_ack_id;
      m_in_ack = n_in_ack; m_spur = n_spur; m_int = n_int;
      check("int_o", int_o, m_int);
      check("irr_o", irr_o, m_irr);
      check("isr_o", isr_o, m_isr);
      check("state", dbg_state_o, m_in_ack);
   endtask

   // driver tasks
   task automatic clear_inputs();
      irq_i = '0; imr_i = '0; level_mode_i = 0; rotate_on_eoi_i = 0; aeoi_i = 0;
      inta_i = 0; eoi_valid_i = 0; eoi_specific_i = 0; eoi_level_i = '0;
      prio_set_valid_i = 0; prio_level_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      #2;
      model_reset();
      exp_q.delete();
      check("rst_int", int_o, 0);
      check("rst_vv", vector_valid_o, 0);
      check("rst_vid", vector_id_o, 0);
      check("rst_spur", spurious_o, 0);
      check("rst_isr", isr_o, 0);
      check("rst_irr", irr_o, 0);
      check("rst_state", dbg_state_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      irq_i = m; tick(); irq_i = '0; tick();
   endtask

   task automatic ack2();
      inta_i = 1; tick(); inta_i = 0; tick();
      inta_i = 1; tick(); inta_i = 0; tick();
   endtask

   task automatic eoi_ns();
      eoi_valid_i = 1; eoi_specific_i = 0; tick(); eoi_valid_i = 0; tick();
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && vector_valid_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vector: got id %0d spur %0b expected none", vector_id_o, spurious_o);
         end else begin
            logic [IW:0] e;
            e = exp_q.pop_front();
            if ({spurious_o, vector_id_o} !== e) begin
               errors++;
               $display("FAIL vector: got spur %0b id %0d expected spur %0b id %0d",
                        spurious_o, vector_id_o, e[IW], e[IW-1:0]);
            end
         end
         last_vec  = int'(vector_id_o);
         last_spur = int'(spurious_o);
      end
   end

   initial begin
      clear_inputs();
      model_reset();
      rst_n = 1'b0;
      @(negedge clk);
      do_reset();

      // nested order, edge mode
      irq_i = 8'h24; tick(); irq_i = '0; tick();
      check("s1_int_at_2", int_o, 1);
      ack2();
      check("s1_vec", last_vec, 2);
      check("s1_isr", isr_o, 8'h04);
      eoi_ns(); tick();
      ack2();
      check("s1_vec2", last_vec, 5);
      eoi_ns();

      // in-service blocks lower priority
      do_reset();
      pulse(8'h08); ack2();
      pulse(8'h30); tick();
      check("s2_blocked", int_o, 0);
      pulse(8'h02);
      check("s2_int", int_o, 1);
      ack2();
      check("s2_vec", last_vec, 1);
      check("s2_isr", isr_o, 8'h0A);

      // rotation on EOI
      do_reset();
      rotate_on_eoi_i = 1;
      pulse(8'h04); ack2(); eoi_ns();
      rotate_on_eoi_i = 0;
      pulse(8'h05); ack2();
      check("s3_vec", last_vec, 0);

      // specific EOI and set-priority together
      do_reset();
      pulse(8'h80); ack2();
      pulse(8'h01); ack2();
      check("s4_isr_pre", isr_o, 8'h81);
      eoi_valid_i = 1; eoi_specific_i = 1; eoi_level_i = 3'd7;
      prio_set_valid_i = 1; prio_level_i = 3'd4;
      tick();
      eoi_valid_i = 0; eoi_specific_i = 0; prio_set_valid_i = 0;
      check("s4_isr", isr_o, 8'h01);
      eoi_ns();
      pulse(8'h21); ack2();
      check("s4_vec", last_vec, 5);

      // spurious acknowledge in level mode
      do_reset();
      level_mode_i = 1; irq_i = 8'h40; tick(); tick();
      check("s5_int", int_o, 1);
      irq_i = '0; tick();
      ack2();
      check("s5_vec", last_vec, 7);
      check("s5_spur", last_spur, 1);
      check("s5_isr", isr_o, 0);
      level_mode_i = 0;

      // AEOI, then reset in the middle of a handshake
      do_reset();
      aeoi_i = 1;
      pulse(8'h10); ack2();
      check("s6_vec", last_vec, 4);
      check("s6_isr", isr_o, 0);
      pulse(8'h10);
      inta_i = 1; tick(); inta_i = 0; tick();
      check("s6_in_ack", dbg_state_o, 1);
      do_reset();
      repeat (4) tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) level_mode_i = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) < 5) imr_i = N'($urandom) & N'($urandom);
         if ($urandom_range(0, 99) < 3) begin
            aeoi_i = 1'($urandom_range(0, 1));
            rotate_on_eoi_i = 1'($urandom_range(0, 1));
         end
         irq_i = irq_i ^ (N'($urandom) & N'($urandom) & N'($urandom));
         inta_i = ($urandom_range(0, 99) < 20);
         eoi_valid_i = ($urandom_range(0, 99) < 10);
         eoi_specific_i = 1'($urandom_range(0, 1));
         eoi_level_i = IW'($urandom_range(0, N - 1));
         prio_set_valid_i = ($urandom_range(0, 99) < 4);
         prio_level_i = IW'($urandom_range(0, N - 1));
         tick();
      end
      clear_inputs();
      repeat (4) tick();
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_priority_controller.md
# irq_priority_controller

Parametrised, registered interrupt-priority engine for the 8259-compatible PIC datapath: it holds the request (IRR) and in-service (ISR) registers and resolves priority in fully-nested or rotating order. It also runs the two-pulse INTA acknowledge handshake and processes EOI and set-priority commands. It sits between the IRQ input pins and the control/cascade logic and supersedes the purely combinational resolver for any channel count.

## Interface
- NUM_IRQ, 8, number of interrupt channels (≥2)
- ID_W, $clog2(NUM_IRQ), width of channel IDs
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- irq_i  input  NUM_IRQ  raw interrupt request lines, already synchronised
- level_mode_i  input  1  1 = level-triggered, 0 = edge-triggered
- imr_i  input  NUM_IRQ  mask; 1 blocks that channel from winning
- rotate_on_eoi_i  input  1  1 = EOI also rotates priority
- aeoi_i  input  1  automatic EOI on second INTA pulse
- inta_i  input  1  one-cycle pulse per INTA bus cycle
- eoi_valid_i  input  1  EOI command strobe
- eoi_specific_i  input  1  1 = specific EOI using eoi_level_i
- eoi_level_i  input  ID_W  channel for specific EOI
- prio_set_valid_i  input  1  set-priority command strobe
- prio_level_i  input  ID_W  new lowest-priority channel
- int_o  output  1  interrupt request to CPU (registered)
- vector_valid_o  output  1  one-cycle strobe, vector_id_o valid
- vector_id_o  output  ID_W  acknowledged channel ID
- spurious_o  output  1  qualifies vector_valid_o: no winner at ack
- isr_o  output  NUM_IRQ  current ISR contents
- irr_o  output  NUM_IRQ  current IRR contents

## Operation
- Priority order: lowest_prio register (ID_W). Highest priority is lowest_prio+1 mod NUM_IRQ, descending around the ring to lowest_prio. lowest_prio = NUM_IRQ-1 gives fully nested (IR0 highest).
- IRR, edge mode: bit set on 0→1 of irq_i (vs. registered irq_prev); cleared on ack of that bit. A new rising edge in the ack cycle wins (bit stays set). IRR, level mode: IRR <= irq_i every cycle.
- Winner: highest-priority bit of IRR & ~imr_i, valid only if strictly higher priority than the highest-priority ISR bit (or ISR empty). Computed combinationally from current registers.
- FSM, IDLE: int_o <= winner_exists.
  - On inta_i: latch winner into ack_id. Set ISR[ack_id]; clear IRR[ack_id] (edge mode). Go ACK1; int_o <= 0.
  - If no winner at that pulse: ack_id = NUM_IRQ-1, spurious flag latched, ISR/IRR untouched.
- FSM, ACK1: int_o held 0. On inta_i: vector_valid_o = 1 for one cycle, vector_id_o = ack_id, spurious_o = flag. Go IDLE.
  - If aeoi_i and not spurious: clear ISR[ack_id]; if rotate_on_eoi_i, lowest_prio <= ack_id.
- EOI, non-specific: clear highest-priority ISR bit (no-op if ISR empty); rotate to it if rotate_on_eoi_i. EOI, specific: clear ISR[eoi_level_i]; rotate to eoi_level_i if enabled.
- Set-priority: lowest_prio <= prio_level_i, ISR unchanged.
- Simultaneous events:
  - ISR_next = (ISR & ~eoi_clear & ~aeoi_clear) | ack_set; all terms use pre-cycle state.
  - Set-priority overrides an EOI/AEOI rotation in the same cycle.
  - EOI accepted in any FSM state.
- IDs ≥ NUM_IRQ on eoi_level_i/prio_level_i: command ignored.

## Timing
- Reset values: IRR, ISR, irq_prev = 0; lowest_prio = NUM_IRQ-1; FSM = IDLE; int_o, vector_valid_o, spurious_o = 0; vector_id_o = 0.
- irq_i edge → IRR set: 1 cycle. IRR → int_o: 1 further cycle (int_o 2 cycles after edge).
- First inta_i → ISR/IRR update visible next cycle; int_o low next cycle.
- Second inta_i → vector_valid_o high the following cycle, exactly one cycle.
- EOI/set-priority take effect next cycle. int_o may re-assert the cycle after that.
- Reset asserted mid-handshake aborts immediately to reset values; no vector is emitted.

## Test plan
- Nested, edge: pulse irq_i[5] then irq_i[2] together → int_o at +2 cycles. Two INTA → vector_id_o=2, ISR=0x04. Non-specific EOI → ISR=0, int_o re-asserts, second ack gives 5.
- Masking/nesting: ISR[3] set, IRR=0x30 → int_o stays 0. Raise irq_i[1] → int_o=1, ack vector 1, ISR=0x0A.
- Rotation: rotate_on_eoi=1, ack 2, non-specific EOI → lowest_prio=2. IRR=0x05 → next ack gives 0? No: order 3..7,0,1,2, so vector 0; IR2 serviced last.
- Specific EOI + set-priority same cycle: ISR=0x81, eoi_level=7, prio_level=4 → ISR=0x01, lowest_prio=4.
- Spurious: level mode, irq_i[6] drops between int_o and first INTA → vector_id_o=7, spurious_o=1, ISR unchanged.
- AEOI: aeoi=1, ack 4 → ISR returns to 0 the cycle after vector_valid_o. Reset asserted in ACK1 → all outputs 0, no vector_valid_o.
